// File: rtl/seg7_scan_driver.sv
// Captures a rotating BCD digit stream into a 4-digit bank and drives a multiplexed
// common-anode 7-segment display with dead time, leading-zero blanking and a react DP.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50,
  parameter int unsigned DEAD_CYC    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic [1:0] sel_in,
  input  logic       react_in,
  input  logic       blank_lz,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 4;

  logic [CW-1:0] cnt;
  logic [1:0]    scan_idx;
  logic [DW-1:0] cap  [4];
  logic [DW-1:0] disp [4];

  logic [1:0]    wr_idx_c;
  logic          wrap_c;
  logic          dead_c;
  logic          blank_c;
  logic [DW-1:0] cur_c;
  logic [6:0]    seg_c;
  logic [3:0]    an_c;

  function automatic logic [6:0] decode(input logic [DW-1:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  // The incoming digit belongs to the slot one behind the rotating select.
  always_comb begin
    wr_idx_c = sel_in - 2'd1;
    wrap_c   = (cnt == CW'(REFRESH_DIV - 1));
    dead_c   = (cnt < CW'(DEAD_CYC));
    cur_c    = disp[scan_idx];
    an_c     = ~(4'b0001 << scan_idx);
    blank_c  = 1'b0;
    case (scan_idx)
      2'd3:    blank_c = (disp[3] == '0);
      2'd2:    blank_c = (disp[3] == '0) && (disp[2] == '0);
      2'd1:    blank_c = (disp[3] == '0) && (disp[2] == '0) && (disp[1] == '0);
      default: blank_c = 1'b0;
    endcase
    seg_c = (blank_lz && blank_c) ? 7'h7F : decode(cur_c);
  end

  // Scan counter, capture/display banks and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      scan_idx <= '0;
      cap      <= '{default: '0};
      disp     <= '{default: '0};
      an_n     <= 4'hF;
      seg_n    <= 7'h7F;
      dp_n     <= 1'b1;
    end else begin
      cnt <= wrap_c ? '0 : cnt + CW'(1);
      if (wrap_c) begin
        scan_idx <= scan_idx + 2'd1;
      end
      // Whole-frame snapshot keeps one capture epoch per displayed frame.
      if (wrap_c && (scan_idx == 2'd3)) begin
        disp <= cap;
      end
      cap[wr_idx_c] <= digit_in;
      if (dead_c) begin
        an_n  <= 4'hF;
        seg_n <= 7'h7F;
        dp_n  <= 1'b1;
      end else begin
        an_n  <= an_c;
        seg_n <= seg_c;
        dp_n  <= ~react_in;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus randomized traffic,
// compared every cycle against a cycle-count based display model.
module tb_seg7_scan_driver;

  localparam int R = 4;
  localparam int D = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit_in;
  logic [1:0] sel_in;
  logic       react_in;
  logic       blank_lz;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  seg7_scan_driver #(.REFRESH_DIV(R), .DEAD_CYC(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .digit_in (digit_in),
    .sel_in   (sel_in),
    .react_in (react_in),
    .blank_lz (blank_lz),
    .an_n     (an_n),
    .seg_n    (seg_n),
    .dp_n     (dp_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // Model state: position is derived from cycles elapsed since reset.
  int         t = 0;
  int         m_cap  [4];
  int         m_disp [4];
  int         last_si = -1;
  int         last_c = -1;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  // Stimulus feeder emulating the timer core's rotating stream.
  bit         feed = 1'b1;
  logic [1:0] fsel = 2'd0;
  logic [3:0] val [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int         c;
    int         si;
    bit         blank;
    logic [3:0] onehot;
    if (rst) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      t = 0; last_si = -1; last_c = -1;
      for (int k = 0; k < 4; k++) begin m_cap[k] = 0; m_disp[k] = 0; end
    end else begin
      c  = t % R;
      si = (t / R) % 4;
      last_c = c; last_si = si;
      if (c < D) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        onehot = 4'b0001 << si;
        e_an = ~onehot;
        blank = 1'b0;
        if (blank_lz && si > 0) begin
          blank = 1'b1;
          for (int k = si; k < 4; k++) if (m_disp[k] != 0) blank = 1'b0;
        end
        e_seg = blank ? 7'h7F : dec_tab[m_disp[si]];
        e_dp = ~react_in;
      end
      if (c == R - 1 && si == 3) m_disp = m_cap;
      m_cap[(int'(sel_in) + 3) % 4] = int'(digit_in);
      t++;
    end
  endtask

  task automatic tick();
    if (feed) begin
      sel_in   = fsel;
      digit_in = val[fsel - 2'd1];
    end
    @(posedge clk);
    model_step();
    if (feed) fsel = fsel + 2'd1;
    @(negedge clk);
    chk("an_n", 7'(an_n), 7'(e_an));
    chk("seg_n", seg_n, e_seg);
    chk("dp_n", 7'(dp_n), 7'(e_dp));
  endtask

  // Advance until the outputs just sampled came from slot si at count c.
  task automatic wait_pos(input int si, input int c);
    int  n = 0;
    bit  hit = 1'b0;
    while (!hit && n < 200) begin
      tick();
      n++;
      hit = (!rst && last_si == si && last_c == c);
    end
    checks++;
    assert (hit) else begin
      failures++;
      $error("FAIL wait_pos observed=timeout expected=slot%0d/cnt%0d", si, c);
    end
  endtask

  task automatic slot_chk(input string tag, input int si, input logic [3:0] an, input logic [6:0] seg);
    wait_pos(si, D);
    chk({tag, "_an"}, 7'(an_n), 7'(an));
    chk({tag, "_seg"}, seg_n, seg);
  endtask

  task automatic frames(input int n);
    repeat (n * 4 * R) tick();
  endtask

  initial begin
    rst = 1'b1; digit_in = 4'd0; sel_in = 2'd0; react_in = 1'b0; blank_lz = 1'b0;

    // Reset held: everything dark.
    repeat (3) begin
      tick();
      chk("rst_an", 7'(an_n), 7'h0F);
      chk("rst_seg", seg_n, 7'h7F);
      chk("rst_dp", 7'(dp_n), 7'h01);
    end
    rst = 1'b0;
    slot_chk("first", 0, 4'hE, 7'h40);

    // Stream 1,2,3,4 (ones..thousands).
    val = '{4'd1, 4'd2, 4'd3, 4'd4};
    frames(2);
    wait_pos(0, 0);
    chk("dead_an", 7'(an_n), 7'h0F);
    slot_chk("d0", 0, 4'hE, 7'h79);
    slot_chk("d1", 1, 4'hD, 7'h24);
    slot_chk("d2", 2, 4'hB, 7'h30);
    slot_chk("d3", 3, 4'h7, 7'h19);

    // Capture changes mid-frame; current frame must stay consistent.
    wait_pos(1, D);
    val = '{4'd8, 4'd7, 4'd6, 4'd5};
    slot_chk("old2", 2, 4'hB, 7'h30);
    slot_chk("old3", 3, 4'h7, 7'h19);
    slot_chk("new0", 0, 4'hE, 7'h00);
    slot_chk("new2", 2, 4'hB, 7'h02);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    val = '{4'd0, 4'd5, 4'd0, 4'd0};
    frames(2);
    slot_chk("lz0", 0, 4'hE, 7'h40);
    slot_chk("lz1", 1, 4'hD, 7'h12);
    slot_chk("lz2", 2, 4'hB, 7'h7F);
    slot_chk("lz3", 3, 4'h7, 7'h7F);
    val = '{4'd0, 4'd0, 4'd0, 4'd0};
    frames(2);
    slot_chk("z0", 0, 4'hE, 7'h40);
    slot_chk("z1", 1, 4'hD, 7'h7F);
    slot_chk("z2", 2, 4'hB, 7'h7F);
    slot_chk("z3", 3, 4'h7, 7'h7F);

    // Non-BCD dash and react decimal point.
    blank_lz = 1'b0;
    react_in = 1'b1;
    val = '{4'd0, 4'd0, 4'd12, 4'd0};
    frames(2);
    slot_chk("dash", 2, 4'hB, 7'h3F);
    chk("dp_lit", 7'(dp_n), 7'h00);
    wait_pos(3, 0);
    chk("dp_dead", 7'(dp_n), 7'h01);

    // Mid-scan reset at scan_idx=2, cnt=2.
    val = '{4'd9, 4'd9, 4'd9, 4'd9};
    frames(2);
    wait_pos(2, 1);
    rst = 1'b1;
    tick();
    chk("mrst_an", 7'(an_n), 7'h0F);
    chk("mrst_seg", seg_n, 7'h7F);
    chk("mrst_dp", 7'(dp_n), 7'h01);
    rst = 1'b0;
    react_in = 1'b0;
    slot_chk("post0", 0, 4'hE, 7'h40);
    slot_chk("post1", 1, 4'hD, 7'h40);

    // Randomized traffic with occasional resets, checked every cycle by the model.
    feed = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      digit_in = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      sel_in   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) react_in = ~react_in;
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
